// File: rtl/tick_gen_bank.sv
// rtl/tick_gen_bank.sv - bank of programmable one-cycle tick generators with per-channel event counters
// Channels cascade through tick enables only, so everything stays on clk_i.
module tick_gen_bank #(
    parameter int unsigned          CHANNELS    = 4,
    parameter int unsigned          DIV_W       = 32,
    parameter int unsigned          CNT_W       = 32,
    parameter int unsigned          DEFAULT_DIV = 50000,
    parameter logic [CHANNELS-1:0]  CASCADE     = '0
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [CHANNELS-1:0]       en_i,
    input  logic                      cfg_wr_i,
    input  logic [3:0]                cfg_ch_i,
    input  logic [DIV_W-1:0]          cfg_div_i,
    input  logic                      cfg_oneshot_i,
    output logic [CHANNELS-1:0]       tick_o,
    output logic [CHANNELS-1:0]       active_o,
    output logic [CHANNELS*CNT_W-1:0] count_o
);

    logic [CHANNELS-1:0] tick_vec;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [DIV_W-1:0] div_q, div_d;
        logic [DIV_W-1:0] p_q, p_d;
        logic [DIV_W-1:0] last_p;
        logic [CNT_W-1:0] ev_q, ev_d;
        logic             oneshot_q, oneshot_d;
        logic             armed_q, armed_d;
        logic             tick_q, tick_d;
        logic             src;
        logic             go;
        logic             wr_hit;

        // Channel 0 has no upstream; others optionally count the previous channel's registered tick.
        if (k == 0) begin : g_src
            assign src = 1'b1;
        end else begin : g_src
            assign src = CASCADE[k] ? tick_vec[k-1] : 1'b1;
        end

        // A divisor of zero behaves as one, so the terminal prescaler value is 0 in both cases.
        assign last_p = (div_q == '0) ? '0 : div_q - DIV_W'(1);
        assign wr_hit = cfg_wr_i && (cfg_ch_i == 4'(k));
        assign go     = en_i[k] & src & armed_q;

        always_comb begin
            div_d     = div_q;
            oneshot_d = oneshot_q;
            armed_d   = armed_q;
            p_d       = p_q;
            ev_d      = ev_q;
            tick_d    = 1'b0;
            if (wr_hit) begin
                div_d     = cfg_div_i;
                oneshot_d = cfg_oneshot_i;
                armed_d   = 1'b1;
                p_d       = '0;
            end else if (go) begin
                if (p_q == last_p) begin
                    p_d    = '0;
                    tick_d = 1'b1;
                    ev_d   = ev_q + CNT_W'(1);
                    if (oneshot_q) begin
                        armed_d = 1'b0;
                    end
                end else begin
                    p_d = p_q + DIV_W'(1);
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                div_q     <= DIV_W'(DEFAULT_DIV);
                oneshot_q <= 1'b0;
                armed_q   <= 1'b1;
                p_q       <= '0;
                ev_q      <= '0;
                tick_q    <= 1'b0;
            end else begin
                div_q     <= div_d;
                oneshot_q <= oneshot_d;
                armed_q   <= armed_d;
                p_q       <= p_d;
                ev_q      <= ev_d;
                tick_q    <= tick_d;
            end
        end

        assign tick_vec[k]                 = tick_q;
        assign active_o[k]                 = !oneshot_q | armed_q;
        assign count_o[k*CNT_W +: CNT_W]   = ev_q;
    end

    assign tick_o = tick_vec;

endmodule

// File: tb/tb_tick_gen_bank.sv
// tb/tb_tick_gen_bank.sv - randomized and directed checks of tick_gen_bank against a behavioural model
// The model tracks each channel as plain integers updated once per rising edge.
module tb_tick_gen_bank;

    localparam int        NCH  = 4;
    localparam int        CW   = 4;
    localparam int        DW   = 16;
    localparam int        DDIV = 5;
    localparam logic [3:0] CASC = 4'b0010;

    logic            clk = 1'b0;
    logic            reset;
    logic [NCH-1:0]  en;
    logic            cfg_wr;
    logic [3:0]      cfg_ch;
    logic [DW-1:0]   cfg_div;
    logic            cfg_os;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  active;
    logic [NCH*CW-1:0] count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_on = 1'b0;

    int unsigned m_div[NCH];
    int unsigned m_p[NCH];
    int unsigned m_ev[NCH];
    bit          m_os[NCH];
    bit          m_armed[NCH];
    bit          m_tick[NCH];

    tick_gen_bank #(
        .CHANNELS(NCH), .DIV_W(DW), .CNT_W(CW), .DEFAULT_DIV(DDIV), .CASCADE(CASC)
    ) dut (
        .clk_i(clk), .reset_i(reset), .en_i(en), .cfg_wr_i(cfg_wr), .cfg_ch_i(cfg_ch),
        .cfg_div_i(cfg_div), .cfg_oneshot_i(cfg_os), .tick_o(tick), .active_o(active),
        .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit prev[NCH];
        bit src;
        int unsigned d;
        prev = m_tick;
        if (reset) begin
            cyc = 0;
            for (int k = 0; k < NCH; k++) begin
                m_div[k] = DDIV; m_p[k] = 0; m_ev[k] = 0;
                m_os[k] = 0; m_armed[k] = 1; m_tick[k] = 0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < NCH; k++) begin
                if (cfg_wr && cfg_ch == k) begin
                    m_div[k] = cfg_div; m_os[k] = cfg_os;
                    m_p[k] = 0; m_armed[k] = 1; m_tick[k] = 0;
                end else begin
                    src = 1'b1;
                    if (k > 0 && CASC[k]) src = prev[k-1];
                    d = (m_div[k] == 0) ? 1 : m_div[k];
                    m_tick[k] = 0;
                    if (en[k] && src && m_armed[k]) begin
                        if (m_p[k] == d - 1) begin
                            m_p[k] = 0;
                            m_tick[k] = 1;
                            m_ev[k] = (m_ev[k] + 1) % (1 << CW);
                            if (m_os[k]) m_armed[k] = 0;
                        end else begin
                            m_p[k]++;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < NCH; k++) begin
                chk($sformatf("model tick[%0d]", k), 32'(tick[k]), 32'(m_tick[k]));
                chk($sformatf("model active[%0d]", k), 32'(active[k]), 32'(!m_os[k] || m_armed[k]));
                chk($sformatf("model count[%0d]", k), 32'(count[k*CW +: CW]), m_ev[k]);
            end
        end
    end

    task automatic at_edge(input int e);
        int g = 0;
        @(negedge clk);
        while (cyc < e && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) chk("at_edge timeout", 32'(cyc), 32'(e));
    endtask

    // Returns the edge number at which the write was sampled.
    task automatic cfg_write(input int ch, input int dv, input bit os, output int w);
        cfg_wr = 1'b1; cfg_ch = 4'(ch); cfg_div = DW'(dv); cfg_os = os;
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
        w = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2;
        reset = 1'b1; en = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_os = 1'b0;
        @(posedge clk);
        #1 chk_on = 1'b1;
        @(posedge clk);
        #1;
        chk("reset tick", 32'(tick), 32'h0);
        chk("reset active", 32'(active), 32'hf);
        chk("reset count", 32'(count), 32'h0);
        reset = 1'b0; en = 4'b1111;

        // Default divisor 5 on channel 0.
        at_edge(4);  chk("ch0 tick e4", 32'(tick[0]), 32'd0);
        at_edge(5);  chk("ch0 tick e5", 32'(tick[0]), 32'd1);
                     chk("ch0 count e5", 32'(count[3:0]), 32'd1);
        at_edge(10); chk("ch0 tick e10", 32'(tick[0]), 32'd1);
                     chk("ch0 count e10", 32'(count[3:0]), 32'd2);
        at_edge(15); chk("ch0 tick e15", 32'(tick[0]), 32'd1);
                     chk("ch0 count e15", 32'(count[3:0]), 32'd3);

        // One-shot on uncascaded channel 3.
        at_edge(19);
        cfg_write(3, 3, 1'b1, w);
        at_edge(w + 2); chk("os tick before", 32'(tick[3]), 32'd0);
                        chk("os active armed", 32'(active[3]), 32'd1);
        at_edge(w + 3); chk("os tick", 32'(tick[3]), 32'd1);
                        chk("os active drop", 32'(active[3]), 32'd0);
        at_edge(w + 6); chk("os no retick", 32'(tick[3]), 32'd0);
        at_edge(w + 19);
        cfg_write(3, 3, 1'b1, w2);
        at_edge(w2 + 3); chk("os rearm tick", 32'(tick[3]), 32'd1);

        // Cascade: ch0 div 4 feeding ch1 div 3.
        en = 4'b1110;
        at_edge(cyc + 2);
        cfg_write(1, 3, 1'b0, w);
        en = 4'b1111;
        cfg_write(0, 4, 1'b0, w);
        at_edge(w + 4);  chk("casc ch0 e4", 32'(tick[0]), 32'd1);
        at_edge(w + 12); chk("casc ch1 e12", 32'(tick[1]), 32'd0);
        at_edge(w + 13); chk("casc ch1 e13", 32'(tick[1]), 32'd1);
        at_edge(w + 24); chk("casc ch1 e24", 32'(tick[1]), 32'd0);
        at_edge(w + 25); chk("casc ch1 e25", 32'(tick[1]), 32'd1);

        // Divisor 0 then 1 on ch2, with a pause.
        cfg_write(2, 0, 1'b0, w);
        for (int i = 1; i <= 3; i++) begin
            at_edge(w + i); chk("div0 tick", 32'(tick[2]), 32'd1);
        end
        en = 4'b1011;
        for (int i = 4; i <= 6; i++) begin
            at_edge(w + i); chk("paused tick", 32'(tick[2]), 32'd0);
        end
        en = 4'b1111;
        cfg_write(2, 1, 1'b0, w);
        at_edge(w + 1); chk("div1 tick", 32'(tick[2]), 32'd1);

        // Out-of-range channel writes must leave everything alone.
        cfg_write(7, 9, 1'b1, w);
        cfg_write(4, 2, 1'b1, w);
        at_edge(w + 3);

        // Reset mid-count: ch0 at p=3 of div 5 when reset is sampled.
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        at_edge(3);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset tick", 32'(tick), 32'h0);
        chk("midreset count", 32'(count), 32'h0);
        chk("midreset active", 32'(active), 32'hf);
        reset = 1'b0;
        cfg_write(2, 1, 1'b0, w);
        at_edge(4);  chk("rel ch0 e4", 32'(tick[0]), 32'd0);
        at_edge(5);  chk("rel ch0 e5", 32'(tick[0]), 32'd1);
        at_edge(17); chk("wrap count e17", 32'(count[11:8]), 32'd0);
        at_edge(18); chk("wrap count e18", 32'(count[11:8]), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            en = 4'($urandom_range(0, 15) | ((i % 4 == 0) ? 0 : 4'b0001));
            if ($urandom_range(0, 7) == 0) begin
                cfg_wr  = 1'b1;
                cfg_ch  = 4'($urandom_range(0, 7));
                cfg_div = DW'($urandom_range(0, 6));
                cfg_os  = 1'($urandom_range(0, 1));
            end else begin
                cfg_wr = 1'b0;
            end
            if ($urandom_range(0, 149) == 0) reset = 1'b1;
            else reset = 1'b0;
        end
        @(negedge clk);
        cfg_wr = 1'b0; reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_gen_bank.md
# tick_gen_bank

Parametrised bank of programmable tick generators that replaces the fixed, hard-coded `counter` prescaler instances at the system level. It produces one-cycle enable pulses (for the TM1638 scan, the 1 Hz heartbeat and the LCD colour stepping) from one clock. It also keeps a per-channel event count. Channels can be cascaded through enables, never through derived clocks, so the whole design stays on a single clock domain. Divisor and mode are loaded at run time through a simple write port.

## Interface
- `CHANNELS`, default 4: number of independent tick channels (1..16).
- `DIV_W`, default 32: width of each divisor and prescaler counter.
- `CNT_W`, default 32: width of each per-channel event counter.
- `DEFAULT_DIV`, default 50000: divisor loaded into every channel at reset.
- `CASCADE`, default 0: CHANNELS-bit mask. When bit k is 1 (k≥1), channel k counts ticks of channel k-1 instead of clk cycles. Bit 0 is ignored.

- `clk`  in  1: the single clock. All state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `en`  in  CHANNELS: per-channel count enable.
- `cfg_wr`  in  1: one-cycle configuration write strobe.
- `cfg_ch`  in  4: target channel of the write.
- `cfg_div`  in  DIV_W: new divisor.
- `cfg_oneshot`  in  1: new mode. 0 = continuous, 1 = one-shot.
- `tick`  out  CHANNELS: registered one-cycle pulse per channel.
- `active`  out  CHANNELS: channel can still produce ticks.
- `count`  out  CHANNELS*CNT_W: event counters. Channel k occupies `[k*CNT_W +: CNT_W]`.

## Operation
- Per-channel state:
  - `div` (DIV_W)
  - `p` prescaler (DIV_W)
  - `oneshot` (1)
  - `armed` (1)
  - `ev` (CNT_W)
  - `tick` register
- Source pulse `src_k` is 1 every cycle when k==0 or `CASCADE[k]`==0. Otherwise it is the registered `tick[k-1]`.
- Effective divisor `D = (div==0) ? 1 : div`.
- Counting condition `go_k = en[k] & src_k & armed_k`.
- When `go_k`:
  - If `p == D-1`: p←0, tick←1, ev←ev+1 (wraps 2^CNT_W−1 → 0). If oneshot, armed←0.
  - Otherwise: p←p+1, tick←0.
- When `!go_k`: p and ev hold, tick←0. `en` low pauses the channel without clearing p.
- `active[k] = !oneshot_k | armed_k`.
- Configuration write, applied when `cfg_wr` is high and `cfg_ch < CHANNELS`:
  - div←cfg_div, oneshot←cfg_oneshot, p←0, armed←1, tick←0. ev is not cleared.
  - A write has priority over counting in the same cycle. That cycle's source pulse is dropped.
  - `cfg_ch ≥ CHANNELS`: the write is ignored and no state changes.
- Re-arming a finished one-shot channel requires a config write.
- Reset (overrides everything):
  - every `div`←DEFAULT_DIV, oneshot←0, armed←1
  - p←0, ev←0, tick←0
  - Resulting outputs: `tick`=0, `active`=all ones, `count`=0.

## Timing
- Continuous mode, `src` every cycle, `en` high from the first edge after reset deasserts:
  - `tick` is first high in cycle D (edges numbered from 1).
  - After that, `tick` is high once every D cycles, one cycle wide.
- After a config write at edge W, the first tick is at edge W+D, provided en stays high.
- Cascade: stage k sees stage k-1's tick one cycle after that tick is asserted.
  - Chain period is the product of the divisors.
  - Each stage adds one cycle of phase lag.
- `count` updates on the same edge that asserts `tick`.
- Zero-latency paths: none. All outputs are registered, except `active`, which is decoded from registers only.
- Divisor change mid-count takes effect immediately, because p is cleared. There is no glitch tick on a write.

## Test plan
- Single channel, DEFAULT_DIV=5, en=1 after reset:
  - `tick[0]` is high at edges 5, 10, 15.
  - `count[0]` reads 1, 2, 3 at those edges.
  - `tick[0]` is low at all other edges.
- Write ch1 div=3, oneshot=1 at edge 20, en[1]=1:
  - `tick[1]` is high only at edge 23.
  - `active[1]` drops to 0 after edge 23.
  - A second write at edge 40 yields a tick at edge 43.
- CASCADE=4'b0010, ch0 div=4, ch1 div=3:
  - `tick[1]` is first high at edge 13 (ch0 ticks at 4, 8, 12, plus 1 cycle of lag).
  - After that, `tick[1]` repeats every 12 cycles.
- Divisor 0 and 1 on ch2:
  - `tick[2]` is high every cycle that en[2]=1.
  - Deasserting en[2] for 3 cycles gives no ticks and leaves `count[2]` frozen.
- Edge cases:
  - Set CNT_W=4 and run 17 ticks: `count` wraps 15→0 and reads 1 after tick 17.
  - `cfg_wr` with `cfg_ch`=7 while CHANNELS=4: no state change on any channel.
- Reset asserted mid-count, with ch0 at p=3 of div 5:
  - Next edge: `tick`=0, `count`=0, `active`=4'b1111.
  - After release, the first tick returns DEFAULT_DIV cycles later.
